// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
//
// Shared definitions for the RC4 engine blocks. The key-schedule FSM and the
// decrypt writer both import this package.
//
// The state codes are one-hot in their upper bits where a state drives a
// write enable or the finish strobe. Those outputs can then be wired straight
// from state-register flops, with no decode logic in the path. The low nibble
// is a plain index that keeps every code unique.
//
//   bit 6 : finish   (DONE only)
//   bit 5 : ram_wren (WRITE_OUT only)
//   bit 4 : s_wren   (WRITE_SI / WRITE_SJ only)
//   3..0  : state index
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int MSG_LEN         = 32;
  localparam int CYCLES_PER_BYTE = 12;

  localparam int STATE_W      = 7;
  localparam int FINISH_BIT   = 6;
  localparam int RAM_WREN_BIT = 5;
  localparam int S_WREN_BIT   = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 7'b000_0000,
    INIT      = 7'b000_0001,
    INC_I     = 7'b000_0010,
    ADDR_SI   = 7'b000_0011,
    READ_SI   = 7'b000_0100,
    CALC_J    = 7'b000_0101,
    ADDR_SJ   = 7'b000_0110,
    READ_SJ   = 7'b000_0111,
    WRITE_SI  = 7'b001_1000,
    WRITE_SJ  = 7'b001_1001,
    ADDR_F    = 7'b000_1010,
    READ_F    = 7'b000_1011,
    WRITE_OUT = 7'b010_1100,
    CHECK_K   = 7'b000_1101,
    DONE      = 7'b100_1110
  } rc4_state_t;

endpackage

// File: rtl/rc4_decrypt_writer.sv
// -----------------------------------------------------------------------------
// rc4_decrypt_writer
//
// Runs the RC4 pseudo-random generation phase over an S memory that has
// already been key-scheduled. Each keystream byte is XORed with the matching
// byte of the encrypted-message ROM, and the result is written to the
// decrypted-message RAM. When all 2**MSG_ADDR_W bytes have been written,
// finish pulses for one cycle. The handshake is the same start/finish pair
// used by the key-schedule FSM.
//
// Every memory has a synchronous read with one cycle of latency. Each read
// therefore holds its address for two cycles: an ADDR_* cycle, then a READ_*
// cycle in which the returned data is captured.
//
// Ports
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-high; returns to IDLE, clears registers
//   start        : level request, sampled only in IDLE
//   finish       : one-cycle completion strobe
//   s_address    : S-memory address
//   s_data       : S-memory write data
//   s_wren       : S-memory write enable
//   s_q          : S-memory read data (one cycle after address)
//   rom_address  : encrypted-message ROM address
//   rom_q        : encrypted byte (one cycle after address)
//   ram_address  : decrypted-message RAM address
//   ram_data     : decrypted byte
//   ram_wren     : decrypted-message RAM write enable
// -----------------------------------------------------------------------------
module rc4_decrypt_writer
  import rc4_pkg::*;
#(
  parameter int MSG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  finish,
  output logic [7:0]            s_address,
  output logic [7:0]            s_data,
  output logic                  s_wren,
  input  logic [7:0]            s_q,
  output logic [MSG_ADDR_W-1:0] rom_address,
  input  logic [7:0]            rom_q,
  output logic [MSG_ADDR_W-1:0] ram_address,
  output logic [7:0]            ram_data,
  output logic                  ram_wren
);

  // k runs over every message byte; the all-ones value marks the last byte.
  localparam logic [MSG_ADDR_W-1:0] K_LAST = '1;

  rc4_state_t state;
  rc4_state_t next_state;

  logic [7:0]            i;
  logic [7:0]            j;
  logic [MSG_ADDR_W-1:0] k;
  logic [7:0]            si;
  logic [7:0]            sj;
  logic [7:0]            f;
  logic [7:0]            enc;

  // Keystream index into S. Only 8 bits are kept, so the sum wraps mod 256.
  logic [7:0] f_index;
  assign f_index = si + sj;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Any code not listed, including illegal ones, falls
  // back to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:      next_state = start ? INIT : IDLE;
      INIT:      next_state = INC_I;
      INC_I:     next_state = ADDR_SI;
      ADDR_SI:   next_state = READ_SI;
      READ_SI:   next_state = CALC_J;
      CALC_J:    next_state = ADDR_SJ;
      ADDR_SJ:   next_state = READ_SJ;
      READ_SJ:   next_state = WRITE_SI;
      WRITE_SI:  next_state = WRITE_SJ;
      WRITE_SJ:  next_state = ADDR_F;
      ADDR_F:    next_state = READ_F;
      READ_F:    next_state = WRITE_OUT;
      WRITE_OUT: next_state = CHECK_K;
      CHECK_K:   next_state = (k == K_LAST) ? DONE : INC_I;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Address and data muxing. In every state not listed here, all of these
  // stay at zero.
  //
  // The swap states write S[i]=sj and S[j]=si. When i==j, both writes store
  // the same value, so S is left unchanged without any special case.
  //
  // ADDR_F uses si+sj. After the swap, that sum equals S[i]+S[j].
  always_comb begin
    s_address   = 8'h00;
    s_data      = 8'h00;
    rom_address = '0;
    ram_address = '0;
    ram_data    = 8'h00;
    case (state)
      ADDR_SI, READ_SI: begin
        s_address = i;
      end
      ADDR_SJ, READ_SJ: begin
        s_address = j;
      end
      WRITE_SI: begin
        s_address = i;
        s_data    = sj;
      end
      WRITE_SJ: begin
        s_address = j;
        s_data    = si;
      end
      ADDR_F, READ_F: begin
        s_address   = f_index;
        rom_address = k;
      end
      WRITE_OUT: begin
        ram_address = k;
        ram_data    = f ^ enc;
      end
      default: begin
      end
    endcase
  end

  // Strobes come straight from the state flops, so they cannot glitch.
  assign finish   = state[FINISH_BIT];
  assign ram_wren = state[RAM_WREN_BIT];
  assign s_wren   = state[S_WREN_BIT];

  // Datapath registers. Each register updates only in the one state that
  // owns it. The read-capture states take s_q and rom_q, which were
  // addressed in the previous cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i   <= 8'h00;
      j   <= 8'h00;
      k   <= '0;
      si  <= 8'h00;
      sj  <= 8'h00;
      f   <= 8'h00;
      enc <= 8'h00;
    end else begin
      case (state)
        INIT: begin
          i <= 8'h00;
          j <= 8'h00;
          k <= '0;
        end
        INC_I:   i  <= i + 8'd1;
        READ_SI: si <= s_q;
        CALC_J:  j  <= j + si;
        READ_SJ: sj <= s_q;
        READ_F: begin
          f   <= s_q;
          enc <= rom_q;
        end
        CHECK_K: k <= k + 1'b1;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_writer.sv
// -----------------------------------------------------------------------------
// tb_rc4_decrypt_writer
//
// Bench for rc4_decrypt_writer. It provides:
//   - an S memory, an encrypted ROM and a decrypted RAM, each with a
//     one-cycle synchronous read;
//   - a plain-array RC4 keystream model that produces the expected results.
// -----------------------------------------------------------------------------
module tb_rc4_decrypt_writer;
  import rc4_pkg::*;

  localparam int AW = 5;
  localparam int N  = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          finish;
  logic [7:0]    s_address;
  logic [7:0]    s_data;
  logic          s_wren;
  logic [7:0]    s_q;
  logic [AW-1:0] rom_address;
  logic [7:0]    rom_q;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data;
  logic          ram_wren;

  int compared   = 0;
  int mismatched = 0;

  rc4_decrypt_writer #(.MSG_ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .finish      (finish),
    .s_address   (s_address),
    .s_data      (s_data),
    .s_wren      (s_wren),
    .s_q         (s_q),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren)
  );

  // Free-running clock with a 10-unit period.
  always #5 clock = ~clock;

  logic [7:0] s_mem    [256];
  logic [7:0] ram_mem  [N];
  logic [7:0] s_init   [256];
  logic [7:0] rom_init [N];
  logic       load_req = 1'b0;

  // The memories sit around the DUT, each with a one-cycle read latency.
  // A load request copies the prepared S image in and clears the RAM, so
  // results from an earlier run cannot leak into a later check.
  always @(posedge clock) begin
    if (load_req) begin
      s_mem <= s_init;
      for (int x = 0; x < N; x++) ram_mem[x] <= 8'h00;
    end else begin
      if (s_wren)   s_mem[s_address]     <= s_data;
      if (ram_wren) ram_mem[ram_address] <= ram_data;
    end
    s_q   <= s_mem[s_address];
    rom_q <= rom_init[rom_address];
  end

  // Count rising edges so that latencies can be measured in edges.
  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // Log every RAM write address and every finish strobe on the falling edge.
  // When byte 1 is written, take a snapshot of S[2] and S[3].
  int         wren_log   [$];
  int         finish_log [$];
  logic [7:0] snap_s2;
  logic [7:0] snap_s3;
  always @(negedge clock) begin
    if (ram_wren) begin
      wren_log.push_back(int'(ram_address));
      if (ram_address == 1) begin
        snap_s2 <= s_mem[2];
        snap_s3 <= s_mem[3];
      end
    end
    if (finish) finish_log.push_back(cycle);
  end

  // RC4 reference model: the plain PRGA recurrence, written on arrays.
  logic [7:0] m_s   [256];
  logic [7:0] m_ks  [N];
  logic [7:0] plain [N];

  task automatic modelRun();
    int mi;
    int mj;
    logic [7:0] t;
    mi = 0;
    mj = 0;
    for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
    for (int n = 0; n < N; n++) begin
      mi = (mi + 1) % 256;
      mj = (mj + int'(m_s[mi])) % 256;
      t = m_s[mi];
      m_s[mi] = m_s[mj];
      m_s[mj] = t;
      m_ks[n] = m_s[(int'(m_s[mi]) + int'(m_s[mj])) % 256];
    end
  endtask

  // Build a random permutation of 0..255 with a Fisher-Yates shuffle.
  task automatic shuffleS();
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = s_init[x];
      s_init[x] = s_init[r];
      s_init[r] = t;
    end
  endtask

  task automatic loadMemories();
    @(negedge clock);
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  // Pulse start for one edge and return the number of the edge that
  // sampled it.
  task automatic applyStimulus(output int sample_cycle);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 sample_cycle = cycle;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Wait, within a cycle budget, until the finish log reaches the target
  // size. A run that never finishes shows up as a short count.
  task automatic waitFinish(input int target, input string tag);
    int budget;
    budget = 1000;
    while (finish_log.size() < target && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    checkOutput(tag, 64'(finish_log.size()), 64'(target));
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({finish, s_wren, ram_wren, s_address, s_data,
                rom_address, ram_address, ram_data});
  endfunction

  int sample;
  int base_w;
  int base_f;
  int bad;
  int budget;
  string alphabet = "abcdefghijklmnopqrstuvwxyz ";

  initial begin
    // ---- Reset state ----
    reset = 1'b1;
    start = 1'b0;
    for (int x = 0; x < N; x++) rom_init[x] = 8'h00;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_outputs", allOutputs(), 64'd0);
    checkOutput("reset_state", 64'(dut.state), 64'(IDLE));
    @(negedge clock);
    reset = 1'b0;

    // ---- Identity S, all-zero ROM ----
    $display("[TB] identity S, zero ROM");
    loadMemories();
    modelRun();
    base_w = wren_log.size();
    base_f = finish_log.size();
    applyStimulus(sample);
    waitFinish(base_f + 1, "id_finish_seen");
    repeat (5) @(negedge clock);
    #1;
    checkOutput("id_ram0", 64'(ram_mem[0]), 64'h02);
    checkOutput("id_ram1", 64'(ram_mem[1]), 64'h05);
    checkOutput("id_s2_after_b1", 64'(snap_s2), 64'h03);
    checkOutput("id_s3_after_b1", 64'(snap_s3), 64'h02);
    checkOutput("id_finish_count", 64'(finish_log.size() - base_f), 64'd1);
    if (finish_log.size() > base_f)
      checkOutput("id_finish_latency", 64'(finish_log[base_f] - sample), 64'd385);
    checkOutput("id_wren_count", 64'(wren_log.size() - base_w), 64'd32);
    bad = 0;
    for (int x = 0; x < N; x++)
      if (base_w + x >= wren_log.size() || wren_log[base_w + x] != x) bad++;
    checkOutput("id_wren_order", 64'(bad), 64'd0);
    bad = 0;
    for (int x = 0; x < N; x++) if (ram_mem[x] !== (m_ks[x] ^ rom_init[x])) bad++;
    checkOutput("id_ram_vs_model", 64'(bad), 64'd0);

    // ---- Random S, ROM carries a known plaintext; start pokes mid-run ----
    $display("[TB] random S, plaintext recovery");
    shuffleS();
    modelRun();
    for (int x = 0; x < N; x++) begin
      plain[x]    = alphabet[$urandom_range(26, 0)];
      rom_init[x] = m_ks[x] ^ plain[x];
    end
    loadMemories();
    base_f = finish_log.size();
    applyStimulus(sample);
    repeat (40) @(negedge clock);
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    waitFinish(base_f + 1, "pt_finish_seen");
    repeat (5) @(negedge clock);
    #1;
    if (finish_log.size() > base_f)
      checkOutput("pt_finish_latency", 64'(finish_log[base_f] - sample), 64'd385);
    checkOutput("pt_finish_count", 64'(finish_log.size() - base_f), 64'd1);
    checkOutput("pt_ram0", 64'(ram_mem[0]), 64'(plain[0]));
    checkOutput("pt_ram31", 64'(ram_mem[31]), 64'(plain[31]));
    bad = 0;
    for (int x = 0; x < N; x++) if (ram_mem[x] !== plain[x]) bad++;
    checkOutput("pt_ram_all", 64'(bad), 64'd0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
    checkOutput("pt_final_s", 64'(bad), 64'd0);

    // ---- Reset during iteration 10, then a clean rerun ----
    $display("[TB] reset during iteration 10");
    shuffleS();
    for (int x = 0; x < N; x++) rom_init[x] = 8'($urandom);
    modelRun();
    loadMemories();
    base_w = wren_log.size();
    applyStimulus(sample);
    budget = 2000;
    while (wren_log.size() < base_w + 10 && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    checkOutput("rst_reach_iter10", 64'(wren_log.size() - base_w), 64'd10);
    // Four falling edges later the FSM is in READ_SI of iteration 10, with i=11.
    repeat (4) @(negedge clock);
    #1;
    checkOutput("rst_pre_s_address", 64'(s_address), 64'd11);
    reset = 1'b1;
    #1;
    checkOutput("rst_async_outputs", allOutputs(), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    // The key schedule would rebuild S before the next start, so reload it.
    loadMemories();
    base_f = finish_log.size();
    applyStimulus(sample);
    waitFinish(base_f + 1, "rst_rerun_finish");
    repeat (3) @(negedge clock);
    #1;
    bad = 0;
    for (int x = 0; x < N; x++) if (ram_mem[x] !== (m_ks[x] ^ rom_init[x])) bad++;
    checkOutput("rst_rerun_ram", 64'(bad), 64'd0);

    // ---- Start held high across two runs ----
    $display("[TB] start held high");
    base_f = finish_log.size();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 sample = cycle;
    waitFinish(base_f + 2, "held_two_finishes");
    start = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    if (finish_log.size() >= base_f + 2) begin
      checkOutput("held_first_latency", 64'(finish_log[base_f] - sample), 64'd385);
      checkOutput("held_gap", 64'(finish_log[base_f + 1] - finish_log[base_f]), 64'd387);
    end
    checkOutput("held_idle_after", 64'(dut.state), 64'(IDLE));

    // ---- Illegal state code ----
    $display("[TB] illegal state recovery");
    @(negedge clock);
    force dut.state = rc4_state_t'(7'h1F);
    #1 release dut.state;
    @(posedge clock);
    #1;
    checkOutput("illegal_to_idle", 64'(dut.state), 64'(IDLE));
    checkOutput("illegal_outputs", allOutputs(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_writer.md
# rc4_decrypt_writer

Produces the 32-byte plaintext message RAM that the downstream ASCII checker reads. On `start`, runs the RC4 pseudo-random generation phase over an already-key-scheduled 256-byte S memory. Each keystream byte is XORed with the matching byte of the encrypted-message ROM, and the result is written to the decrypted-message RAM. It then pulses `finish`. It sits between the key-schedule FSM and the ASCII checker, and uses the same start/finish handshake.

## Interface
- `MSG_ADDR_W`, default 5: message address width; message length is 2**MSG_ADDR_W bytes (32).
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- `start`  in  1  level; sampled only in IDLE.
- `finish`  out  1  high for exactly one cycle (DONE state).
- `s_address`  out  8  S-memory address.
- `s_data`  out  8  S-memory write data.
- `s_wren`  out  1  S-memory write enable.
- `s_q`  in  8  S-memory read data; valid the cycle after the address is presented.
- `rom_address`  out  MSG_ADDR_W  encrypted-ROM address.
- `rom_q`  in  8  encrypted byte; valid the cycle after the address is presented.
- `ram_address`  out  MSG_ADDR_W  decrypted-RAM address.
- `ram_data`  out  8  decrypted byte.
- `ram_wren`  out  1  decrypted-RAM write enable.

## Operation
- Registers:
  - `i`, `j`: 8 bits.
  - `k`: MSG_ADDR_W bits.
  - `si`, `sj`, `f`, `enc`: 8 bits each.
  - All arithmetic is modulo 256 (i, j, si+sj) or modulo 32 (k); wrap is natural truncation.
- IDLE: if `start`, go to INIT; otherwise stay.
- INIT: i, j, k <= 0.
- Per-byte loop, one cycle per state, in order:
  - INC_I: i <= i+1.
  - ADDR_SI: s_address=i.
  - READ_SI: s_address=i; si <= s_q.
  - CALC_J: j <= j+si.
  - ADDR_SJ: s_address=j.
  - READ_SJ: s_address=j; sj <= s_q.
  - WRITE_SI: s_address=i, s_data=sj, s_wren=1.
  - WRITE_SJ: s_address=j, s_data=si, s_wren=1.
  - ADDR_F: s_address=si+sj; rom_address=k.
  - READ_F: same addresses; f <= s_q; enc <= rom_q.
  - WRITE_OUT: ram_address=k, ram_data=f^enc, ram_wren=1.
  - CHECK_K: k <= k+1. If k was 31, go to DONE; otherwise go to INC_I.
- DONE: finish=1; go to IDLE.
- When i==j, the two swap writes store the same value; S is unchanged. No special case is required.
- Outside the listed states:
  - All write enables are 0.
  - All addresses and `s_data` are 0.
  - `rom_address` and `ram_address` are 0 except where listed.
- Write enables and `finish` are taken directly from state-register bits, with no combinational decode, so they are glitch-free.
- `start` is ignored outside IDLE. A `start` held high restarts the block after passing through IDLE for one cycle.
- Unknown or illegal state codes go to IDLE.

## Timing
- Reset value of every output is 0; state is IDLE.
- Per byte: 12 cycles.
- `finish` rises 1 + 32×12 = 385 edges after the edge that samples `start` in IDLE.
- Byte k is written during the WRITE_OUT cycle of iteration k. RAM writes are strictly in order 0..31.
- Reset asserted mid-operation: outputs return to 0 immediately (asynchronously).
  - S memory and RAM keep whatever partial writes already occurred.
  - The next `start` restarts with i=j=k=0.
- Memory model: synchronous read, one-cycle latency. The address is held for two consecutive cycles around each read.

## Structure
- Shared package `rc4_pkg`:
  - State encoding constants, with output bits embedded in the code.
  - `MSG_LEN`=32.
  - `CYCLES_PER_BYTE`=12.
  - This package is also importable by the key-schedule FSM.
- Single module; no sub-module. Datapath registers and the FSM live together.

## Test plan
- Identity S (s[x]=x) and ROM all 0x00, pulse start:
  - ram[0]=0x02 and ram[1]=0x05.
  - After byte 1, s[2]=0x03 and s[3]=0x02.
  - Byte 0 exercises i==j=1.
- Same setup: `finish` is high exactly once, 385 edges after start is sampled. Exactly 32 `ram_wren` pulses occur, at addresses 0..31 in order.
- ROM = golden-model keystream XOR "abc…" (lowercase or space): RAM equals the plaintext byte-for-byte. S memory matches the golden model's final S.
- Assert reset during iteration 10:
  - All outputs are 0 within the same cycle.
  - After reset deasserts and start is pulsed, the full run completes and ram[0..31] matches the golden model from the original S.
- Hold start high across two runs: the second run begins one IDLE cycle after `finish`. `start` pulses during a run have no effect.
- Force an illegal state code: the FSM enters IDLE on the next edge with all outputs 0.
